mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Iterative signed multiply/divide responder for the multi-cycle MIPS datapath.
// - The control unit initiates an operation with a one-cycle start pulse (MultCtrl / DivCtrl),
//   supplying operands from the A/B registers.
// - This block computes the result, signals completion and reports divide-by-zero.
// - The datapath loads hi/lo into HiReg/LOReg on done.
// PARAMETERS
// - WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
// - clock       in   1      system clock
// - reset       in   1      synchronous, active-high reset
// - start_mult  in   1      1-cycle request: signed a*b
// - start_div   in   1      1-cycle request: signed a/b
// - a           in   WIDTH  multiplicand / dividend (RegA)
// - b           in   WIDTH  multiplier / divisor (RegB)
// - busy        out  1      operation in progress
// - done        out  1      1-cycle pulse: hi/lo valid
// - div_zero    out  1      1-cycle pulse with done: divisor was 0
// - hi          out  WIDTH  mult: product[63:32]; div: remainder
// - lo          out  WIDTH  mult: product[31:0];  div: quotient
// BEHAVIOUR
// - Interface: one clock (clock); reset is synchronous, active-high (reset).
// - Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
//   A reset mid-operation aborts the operation with no done pulse.
// - FSM states:
//   - IDLE
//     - start_mult -> MUL; start_div -> DIV, or DZ if b==0.
//     - Operands are latched on the accepting edge.
//     - If both starts are high, mult wins and start_div is dropped.
//   - MUL: radix-2 Booth on {acc,WIDTH-bit Q,q-1}; one step per cycle for WIDTH cycles -> FIN.
//   - DIV: restoring divide on |a|,|b|; one step per cycle for WIDTH cycles -> FIN.
//   - FIN: apply sign fix; load hi/lo; done=1 for this cycle -> IDLE.
//   - DZ: done=1, div_zero=1 for one cycle; hi/lo unchanged -> IDLE.
// - Latency:
//   - start sampled at edge k -> done high in the cycle after edge k+WIDTH+1 (33 cycles for WIDTH=32).
//   - Divide-by-zero: done in the cycle after edge k+1.
// - busy: 1 in MUL/DIV/FIN/DZ; 0 in IDLE. Starts received while busy=1 are ignored, not queued.
// - Arithmetic:
//   - Product is the full 2*WIDTH signed result and cannot overflow.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - Corner case -2^(WIDTH-1) / -1: lo=0x80000000, hi=0, div_zero=0. Wraps silently; no overflow flag.
// - hi/lo change only in FIN, so they hold their value between operations.
//   A start accepted in the cycle after done is legal (back-to-back).
// - The iteration counter is log2(WIDTH)+1 bits and counts down from WIDTH to 0.
// STRUCTURE
// - Package mult_div_pkg:
//   - md_state_t enum {IDLE,MUL,DIV,FIN,DZ}
//   - MD_WIDTH=32
//   - localparam CNT_W
// - One sub-module, md_sign_fix (combinational): conditionally negates the quotient,
//   remainder and 2*WIDTH product from the latched sign bits.
// - The FSM, Booth datapath and restoring datapath all live in this module.
// TESTING
// - Mult: a=7, b=-3 -> 33 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 throughout.
// - Mult: a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
// - Div: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0;
//   then a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
// - Div by zero: hi/lo preloaded 5/9, a=10, b=0 -> next cycle done=1, div_zero=1, hi=5, lo=9.
// - Protocol:
//   - start_mult and start_div together -> mult result only.
//   - start_div pulsed while busy -> ignored.
//   - Back-to-back start the cycle after done -> accepted.
// - Reset asserted at cycle 10 of a mult -> next cycle busy=0, no done pulse ever; hi=lo=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative signed multiply/divide unit:
//   - MD_WIDTH   default operand width
//   - cnt_width  width of an iteration counter that must hold the value WIDTH
//   - CNT_W      counter width for the default operand width
//   - md_state_t controller states
// ----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    // The counter is loaded with WIDTH itself, so it needs one bit more than
    // log2(WIDTH).
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(MD_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIN,
        DZ
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// ----------------------------------------------------------------------------
// md_sign_fix
// Combinational sign correction applied to the raw iteration results.
// The divider works on magnitudes, so its quotient and remainder are negated
// here. The product path takes a separate negate control.
// Ports:
//   neg_quo     in   1        negate the quotient
//   neg_rem     in   1        negate the remainder
//   neg_prod    in   1        negate the 2*WIDTH product
//   quo         in   WIDTH    unsigned quotient
//   rem         in   WIDTH    unsigned remainder
//   prod        in   2*WIDTH  raw product
//   quo_fixed   out  WIDTH    signed quotient
//   rem_fixed   out  WIDTH    signed remainder
//   prod_fixed  out  2*WIDTH  signed product
// ----------------------------------------------------------------------------
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic                 neg_quo,
    input  logic                 neg_rem,
    input  logic                 neg_prod,
    input  logic [WIDTH-1:0]     quo,
    input  logic [WIDTH-1:0]     rem,
    input  logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quo_fixed,
    output logic [WIDTH-1:0]     rem_fixed,
    output logic [2*WIDTH-1:0]   prod_fixed
);

    assign quo_fixed  = neg_quo  ? -quo  : quo;
    assign rem_fixed  = neg_rem  ? -rem  : rem;
    assign prod_fixed = neg_prod ? -prod : prod;

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Iterative signed multiply / divide for the multi-cycle datapath.
// Multiply uses radix-2 Booth recoding, divide uses restoring division on the
// operand magnitudes; both take WIDTH iteration cycles plus one finishing
// cycle. Divide by zero completes after a single cycle and leaves hi/lo alone.
// Ports:
//   clock       in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   start_mult  in   1      1-cycle request: signed a*b
//   start_div   in   1      1-cycle request: signed a/b
//   a           in   WIDTH  multiplicand / dividend
//   b           in   WIDTH  multiplier / divisor
//   busy        out  1      operation in progress
//   done        out  1      1-cycle pulse: hi/lo valid
//   div_zero    out  1      1-cycle pulse with done: divisor was zero
//   hi          out  WIDTH  mult: product upper half; div: remainder
//   lo          out  WIDTH  mult: product lower half; div: quotient
// ----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    md_state_t        state;
    logic [CW-1:0]    counter;

    // Shared datapath registers.
    //   Booth:     {acc, q, q_m1} is the shifting triple, m the multiplicand.
    //              acc carries one guard bit so that subtracting the most
    //              negative multiplicand cannot overflow.
    //   Restoring: acc is the partial remainder, q shifts the dividend out and
    //              the quotient in, m holds |divisor|.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [2*WIDTH-1:0] prod_fixed;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        m_ext     = {m[WIDTH-1], m};
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m};
    end

    // Booth already produces a two's-complement product, so the product path
    // is never negated; only the divider results need correcting.
    md_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .neg_quo    (sign_a ^ sign_b),
        .neg_rem    (sign_a),
        .neg_prod   (1'b0),
        .quo        (q),
        .rem        (acc[WIDTH-1:0]),
        .prod       ({acc[WIDTH-1:0], q}),
        .quo_fixed  (quo_fixed),
        .rem_fixed  (rem_fixed),
        .prod_fixed (prod_fixed)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            counter  <= '0;
            acc      <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            m        <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    // Multiply has priority when both requests arrive together.
                    if (start_mult) begin
                        state   <= MUL;
                        busy    <= 1'b1;
                        counter <= CW'(WIDTH);
                        acc     <= '0;
                        q       <= a;
                        q_m1    <= 1'b0;
                        m       <= b;
                        is_div  <= 1'b0;
                    end else if (start_div) begin
                        busy    <= 1'b1;
                        is_div  <= 1'b1;
                        sign_a  <= a[WIDTH-1];
                        sign_b  <= b[WIDTH-1];
                        if (b == '0) begin
                            state <= DZ;
                        end else begin
                            state   <= DIV;
                            counter <= CW'(WIDTH);
                            acc     <= '0;
                            q       <= a_mag;
                            m       <= b_mag;
                        end
                    end
                end
                MUL: begin
                    // Add/subtract then arithmetic shift right of {acc,q,q_m1}.
                    acc     <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q       <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1    <= q[0];
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) state <= FIN;
                end
                DIV: begin
                    // A set top bit means the trial subtraction went negative:
                    // keep the shifted remainder and record a 0 quotient bit.
                    if (div_diff[WIDTH]) begin
                        acc <= div_shift;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= div_diff;
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) state <= FIN;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                DZ: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. A behavioural model computes results
// with plain 64-bit arithmetic and tracks completion as a countdown of cycles;
// a compare process checks every DUT output against it each cycle, and the
// directed sequence pins literal expected results, latencies and protocol.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_mult;
    logic         start_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int passed = 0;
    int total  = 0;
    logic cmp_en = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: results from 64-bit signed arithmetic, timing as
    // "cycles remaining until done" after an accepted request.
    // ------------------------------------------------------------------
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo;
    logic [W-1:0] pend_hi, pend_lo;
    logic         pend_dz;
    int           m_left;

    always @(posedge clock) begin
        longint       la, lb, lq, lr;
        logic [63:0]  p;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dz   = pend_dz;
                    m_hi   = pend_hi;
                    m_lo   = pend_lo;
                end
            end else if (start_mult || start_div) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                m_busy  = 1'b1;
                pend_dz = 1'b0;
                if (start_mult) begin
                    p = 64'(la * lb);
                    pend_hi = p[63:32];
                    pend_lo = p[31:0];
                    m_left  = W + 1;
                end else if (b == '0) begin
                    pend_dz = 1'b1;
                    pend_hi = m_hi;
                    pend_lo = m_lo;
                    m_left  = 1;
                end else begin
                    lq = la / lb;
                    lr = la % lb;
                    p = 64'(lq); pend_lo = p[31:0];
                    p = 64'(lr); pend_hi = p[31:0];
                    m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_busy",     64'(busy),     64'(m_busy));
            check("model_done",     64'(done),     64'(m_done));
            check("model_div_zero", 64'(div_zero), 64'(m_dz));
            check("model_hi",       64'(hi),       64'(m_hi));
            check("model_lo",       64'(lo),       64'(m_lo));
        end
    end

    // Issue one request and wait (bounded) for done; checks literal results.
    task automatic run_op(input logic sm, input logic sd, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_lat);
        int lat;
        start_mult = sm; start_div = sd; a = aa; b = bb;
        @(negedge clock);
        start_mult = 1'b0; start_div = 1'b0;
        lat = 0;
        while (!done && lat < 50) begin
            check("busy_while_running", 64'(busy), 64'd1);
            @(negedge clock);
            lat++;
        end
        check("latency",  64'(lat),      64'(exp_lat));
        check("hi",       64'(hi),       64'(exp_hi));
        check("lo",       64'(lo),       64'(exp_lo));
        check("div_zero", 64'(div_zero), 64'(exp_dz));
    endtask

    initial begin
        int lat;
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Multiply cases.
        run_op(1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33);
        run_op(1, 0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 33);
        // Divide cases, including the silent overflow corner.
        run_op(0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
        run_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 33);
        // Preload hi=5, lo=9, then divide by zero leaves them untouched.
        run_op(0, 1, 32'd95,         32'd10,        32'd5,         32'd9,         0, 33);
        run_op(0, 1, 32'd10,         32'd0,         32'd5,         32'd9,         1, 1);
        // Both starts together: multiply wins (6*4, not 6/4).
        run_op(1, 1, 32'd6,          32'd4,         32'd0,         32'd24,        0, 33);
        // Back-to-back: start in the cycle after done.
        @(negedge clock);
        run_op(0, 1, 32'd100,        32'd7,         32'd2,         32'd14,        0, 33);

        // start_div while busy is ignored.
        @(negedge clock);
        start_mult = 1'b1; a = 32'd3; b = 32'd5;
        @(negedge clock);
        start_mult = 1'b0;
        lat = 0;
        while (!done && lat < 50) begin
            start_div = (lat == 4);
            if (lat == 4) begin a = 32'd100; b = 32'd7; end
            @(negedge clock);
            lat++;
        end
        start_div = 1'b0;
        check("ignored_latency", 64'(lat), 64'd33);
        check("ignored_hi",      64'(hi),  64'd0);
        check("ignored_lo",      64'(lo),  64'd15);
        repeat (40) begin
            @(negedge clock);
            check("ignored_no_done", 64'(done), 64'd0);
        end

        // Reset at cycle 10 of a multiply aborts it.
        start_mult = 1'b1; a = 32'd123; b = 32'd456;
        @(negedge clock);
        start_mult = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        repeat (40) begin
            @(negedge clock);
            check("abort_no_done", 64'(done), 64'd0);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
